// File: rtl/chip8_pkg.sv
// ============================================================================
// Module      : chip8_pkg
// Description : Shared definitions for the CHIP-8 8XYN execute sequencer:
//               ALU op codes, sequencer state encoding and the legal-N test.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chip8_pkg;

  // ALU operation codes, equal to the low nibble of an 8XYN opcode
  localparam logic [3:0] ALU_LD  = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [3:0] ALU_SUB = 4'h5;
  localparam logic [3:0] ALU_SHR = 4'h6;
  localparam logic [3:0] ALU_RSB = 4'h7;
  localparam logic [3:0] ALU_SHL = 4'hE;

  // Sequencer state encoding
  localparam logic [2:0] C_ST_IDLE  = 3'd0;
  localparam logic [2:0] C_ST_RD_X  = 3'd1;
  localparam logic [2:0] C_ST_RD_Y  = 3'd2;
  localparam logic [2:0] C_ST_CAP   = 3'd3;
  localparam logic [2:0] C_ST_EXEC  = 3'd4;
  localparam logic [2:0] C_ST_WB_VF = 3'd5;
  localparam logic [2:0] C_ST_ILL   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = C_ST_IDLE,
    ST_RD_X  = C_ST_RD_X,
    ST_RD_Y  = C_ST_RD_Y,
    ST_CAP   = C_ST_CAP,
    ST_EXEC  = C_ST_EXEC,
    ST_WB_VF = C_ST_WB_VF,
    ST_ILL   = C_ST_ILL
  } state_t;

  // True for the N nibbles the ALU implements
  function automatic logic is_legal_n(input logic [3:0] n);
    logic ok;
    case (n)
      ALU_LD, ALU_OR, ALU_AND, ALU_XOR,
      ALU_ADD, ALU_SUB, ALU_SHR, ALU_RSB, ALU_SHL: ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chip8_alu_seq.sv
// ============================================================================
// Module      : chip8_alu_seq
// Description : Execute sequencer for CHIP-8 8XYN register-register
//               instructions. Reads Vx then Vy through one synchronous
//               register-file port, drives the external combinational ALU,
//               writes Vx and then (if requested by the ALU) VF.
// Optional    : CHIP8_SHIFT_VY_QUIRK_EN - shifts (N=6/E) take Vy as the
//               operand (COSMAC behaviour); default shifts Vx in place.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               op_valid/op_ready     - opcode handshake
//               opcode                - {4'h8, x, y, n}
//               done / illegal        - one-cycle retire / reject pulses
//               rf_raddr / rf_rdata   - register-file read port (1-cycle)
//               rf_we/waddr/wdata     - register-file write port
//               alu_a/b/op            - ALU operands and op
//               alu_out/vf_wr/carry   - ALU result, VF request, flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chip8_alu_seq
  import chip8_pkg::*;
#(
  parameter logic [3:0] VF_ADDR   = 4'hF,
  parameter int         RF_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] opcode,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  rf_raddr,
  input  logic [7:0]  rf_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_out,
  input  logic        alu_vf_wr,
  input  logic        alu_carry
);

  // The read pipeline below assumes data arrives exactly one cycle after the
  // address; any other latency would silently misalign the operand captures.
  generate
    if (RF_RD_LAT != 1) begin : g_bad_rd_lat
      $error("chip8_alu_seq: RF_RD_LAT must be 1");
    end
  endgenerate

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_x;
  logic [3:0] r_y;
  logic [3:0] r_n;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_flag;
  logic       r_vfw;
  logic       w_legal;
  logic       w_xfer;
  logic       w_shift_vy;

  assign w_legal = (opcode[15:12] == 4'h8) && is_legal_n(opcode[3:0]);
  assign w_xfer  = op_valid && (r_state == ST_IDLE);

`ifdef CHIP8_SHIFT_VY_QUIRK_EN
  assign w_shift_vy = (r_n == ALU_SHR) || (r_n == ALU_SHL);
`else
  assign w_shift_vy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x     <= 4'h0;
      r_y     <= 4'h0;
      r_n     <= 4'h0;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_flag  <= 1'b0;
      r_vfw   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_x <= opcode[11:8];
        r_y <= opcode[7:4];
        r_n <= opcode[3:0];
      end
      // Read data lags the address by one cycle: Vx lands while Vy is
      // being addressed, Vy lands in CAP.
      if (r_state == ST_RD_Y) r_a <= rf_rdata;
      if (r_state == ST_CAP)  r_b <= rf_rdata;
      if (r_state == ST_EXEC) begin
        r_flag <= alu_carry;
        r_vfw  <= alu_vf_wr;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    op_ready = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    rf_raddr = 4'h0;
    rf_we    = 1'b0;
    rf_waddr = 4'h0;
    rf_wdata = 8'h00;
    alu_a    = r_a;
    alu_b    = r_b;
    alu_op   = r_n;

    case (r_state)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) w_next = w_legal ? ST_RD_X : ST_ILL;
      end
      ST_RD_X: begin
        rf_raddr = r_x;
        w_next   = ST_RD_Y;
      end
      ST_RD_Y: begin
        rf_raddr = r_y;
        w_next   = ST_CAP;
      end
      ST_CAP: begin
        w_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_shift_vy) alu_a = r_b;
        rf_we    = 1'b1;
        rf_waddr = r_x;
        rf_wdata = alu_out;
        if (alu_vf_wr) begin
          w_next = ST_WB_VF;
        end else begin
          done   = 1'b1;
          w_next = ST_IDLE;
        end
      end
      ST_WB_VF: begin
        // Issued strictly after the Vx write so that x==F ends with the flag
        rf_we    = r_vfw;
        rf_waddr = VF_ADDR;
        rf_wdata = {7'b0, r_flag};
        done     = 1'b1;
        w_next   = ST_IDLE;
      end
      ST_ILL: begin
        illegal = 1'b1;
        w_next  = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    // Reset aborts the instruction in the cycle it is asserted
    if (rst) begin
      rf_we   = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_chip8_alu_seq.sv
// ============================================================================
// Module      : tb_chip8_alu_seq
// Description : Directed self-checking bench for chip8_alu_seq with a
//               behavioural ALU and a 16x8 register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chip8_alu_seq;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] opcode;
  logic        done;
  logic        illegal;
  logic [3:0]  rf_raddr;
  logic [7:0]  rf_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_op;
  logic [7:0]  alu_out;
  logic        alu_vf_wr;
  logic        alu_carry;

  int total;
  int bad;

  chip8_alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .opcode    (opcode),
    .done      (done),
    .illegal   (illegal),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_vf_wr (alu_vf_wr),
    .alu_carry (alu_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: one synchronous read port, one write port, plus a
  // bench-side preload port
  logic [7:0] rf [16];
  logic       pl_we;
  logic [3:0] pl_a;
  logic [7:0] pl_d;

  always @(posedge clk) begin
    rf_rdata <= rf[rf_raddr];
    if (pl_we)      rf[pl_a]     <= pl_d;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  // Behavioural ALU (modern CHIP-8 semantics)
  logic [8:0] w_sum;
  always_comb begin
    alu_out   = 8'h00;
    alu_vf_wr = 1'b0;
    alu_carry = 1'b0;
    w_sum     = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_op)
      4'h0: alu_out = alu_b;
      4'h1: alu_out = alu_a | alu_b;
      4'h2: alu_out = alu_a & alu_b;
      4'h3: alu_out = alu_a ^ alu_b;
      4'h4: begin alu_out = w_sum[7:0];    alu_vf_wr = 1'b1; alu_carry = w_sum[8];         end
      4'h5: begin alu_out = alu_a - alu_b; alu_vf_wr = 1'b1; alu_carry = (alu_a >= alu_b); end
      4'h6: begin alu_out = alu_a >> 1;    alu_vf_wr = 1'b1; alu_carry = alu_a[0];         end
      4'h7: begin alu_out = alu_b - alu_a; alu_vf_wr = 1'b1; alu_carry = (alu_b >= alu_a); end
      4'hE: begin alu_out = alu_a << 1;    alu_vf_wr = 1'b1; alu_carry = alu_a[7];         end
      default: ;
    endcase
  end

  // Per-cycle trace of outputs for cycles N+1..N+7 after a transfer at N
  logic       tr_we   [1:7];
  logic [3:0] tr_wa   [1:7];
  logic [7:0] tr_wd   [1:7];
  logic       tr_done [1:7];
  logic       tr_ill  [1:7];
  logic       tr_rdy  [1:7];
  logic [7:0] tr_alua [1:7];
  logic [3:0] tr_aop  [1:7];
  logic       acc_rdy;

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic issue(input logic [15:0] op);
    @(negedge clk);
    op_valid = 1'b1;
    opcode   = op;
    acc_rdy  = op_ready;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin op_valid = 1'b0; opcode = 16'h0000; end
      tr_we[k]   = rf_we;
      tr_wa[k]   = rf_waddr;
      tr_wd[k]   = rf_wdata;
      tr_done[k] = done;
      tr_ill[k]  = illegal;
      tr_rdy[k]  = op_ready;
      tr_alua[k] = alu_a;
      tr_aop[k]  = alu_op;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", op_ready); end
    total++; if ({done, illegal, rf_we} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {done, illegal, rf_we}); end
    total++; if ({rf_raddr, rf_waddr, rf_wdata, alu_a, alu_b, alu_op} !== 40'h0) begin bad++;
      $display("FAIL reset_buses got=%h want=0", {rf_raddr, rf_waddr, rf_wdata, alu_a, alu_b, alu_op}); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", op_ready); end
  endtask

  task automatic test_add();
    preload(4'h1, 8'hF0); preload(4'h2, 8'h20); preload(4'hF, 8'h55);
    issue(16'h8124);
    total++; if (acc_rdy !== 1'b1) begin bad++; $display("FAIL add_accept got=%b want=1", acc_rdy); end
    for (int k = 1; k <= 3; k++) begin
      total++; if (tr_we[k] !== 1'b0) begin bad++; $display("FAIL add_early_we k=%0d got=%b want=0", k, tr_we[k]); end
    end
    total++; if ({tr_we[4], tr_wa[4], tr_wd[4]} !== {1'b1, 4'h1, 8'h10}) begin bad++;
      $display("FAIL add_vx_write got=%b/%h/%h want=1/1/10", tr_we[4], tr_wa[4], tr_wd[4]); end
    total++; if (tr_aop[4] !== 4'h4) begin bad++; $display("FAIL add_aluop got=%h want=4", tr_aop[4]); end
    total++; if ({tr_we[5], tr_wa[5], tr_wd[5]} !== {1'b1, 4'hF, 8'h01}) begin bad++;
      $display("FAIL add_vf_write got=%b/%h/%h want=1/f/01", tr_we[5], tr_wa[5], tr_wd[5]); end
    total++; if ({tr_done[4], tr_done[5], tr_done[6]} !== 3'b010) begin bad++;
      $display("FAIL add_done got=%b want=010", {tr_done[4], tr_done[5], tr_done[6]}); end
    total++; if ({tr_rdy[5], tr_rdy[6]} !== 2'b01) begin bad++; $display("FAIL add_ready got=%b want=01", {tr_rdy[5], tr_rdy[6]}); end
    total++; if ({rf[1], rf[15]} !== 16'h1001) begin bad++; $display("FAIL add_final got=%h want=1001", {rf[1], rf[15]}); end
  endtask

  task automatic test_sub_rsb();
    preload(4'h1, 8'h10); preload(4'h2, 8'h20);
    issue(16'h8125);
    total++; if ({rf[1], rf[15]} !== 16'hF000) begin bad++; $display("FAIL sub_final got=%h want=f000", {rf[1], rf[15]}); end
    total++; if (tr_done[5] !== 1'b1) begin bad++; $display("FAIL sub_done got=%b want=1", tr_done[5]); end
    preload(4'h1, 8'h10); preload(4'h2, 8'h30);
    issue(16'h8127);
    total++; if ({rf[1], rf[15]} !== 16'h2001) begin bad++; $display("FAIL rsb_final got=%h want=2001", {rf[1], rf[15]}); end
  endtask

  task automatic test_vf_dest();
    preload(4'hF, 8'h90); preload(4'h1, 8'h90);
    issue(16'h8F14);
    total++; if ({tr_we[4], tr_wa[4], tr_wd[4]} !== {1'b1, 4'hF, 8'h20}) begin bad++;
      $display("FAIL vfdst_vx got=%b/%h/%h want=1/f/20", tr_we[4], tr_wa[4], tr_wd[4]); end
    total++; if ({tr_we[5], tr_wa[5], tr_wd[5]} !== {1'b1, 4'hF, 8'h01}) begin bad++;
      $display("FAIL vfdst_flag got=%b/%h/%h want=1/f/01", tr_we[5], tr_wa[5], tr_wd[5]); end
    total++; if (rf[15] !== 8'h01) begin bad++; $display("FAIL vfdst_final got=%h want=01", rf[15]); end
  endtask

  task automatic test_shift();
    logic [7:0] exp_v0, exp_vf, exp_a;
`ifdef CHIP8_SHIFT_VY_QUIRK_EN
    exp_v0 = 8'h01; exp_vf = 8'h00; exp_a = 8'h02;
`else
    exp_v0 = 8'h40; exp_vf = 8'h01; exp_a = 8'h81;
`endif
    preload(4'h0, 8'h81); preload(4'h1, 8'h02);
    issue(16'h8016);
    total++; if (tr_alua[4] !== exp_a) begin bad++; $display("FAIL shr_alu_a got=%h want=%h", tr_alua[4], exp_a); end
    total++; if ({rf[0], rf[15]} !== {exp_v0, exp_vf}) begin bad++;
      $display("FAIL shr_final got=%h want=%h", {rf[0], rf[15]}, {exp_v0, exp_vf}); end
  endtask

  task automatic test_no_vf();
    preload(4'h0, 8'hF0); preload(4'h1, 8'h3C); preload(4'hF, 8'h77);
    issue(16'h8012);
    total++; if ({tr_we[4], tr_wa[4], tr_wd[4], tr_done[4]} !== {1'b1, 4'h0, 8'h30, 1'b1}) begin bad++;
      $display("FAIL and_exec got=%b/%h/%h/%b want=1/0/30/1", tr_we[4], tr_wa[4], tr_wd[4], tr_done[4]); end
    total++; if ({tr_we[5], tr_done[5], tr_rdy[5]} !== 3'b001) begin bad++;
      $display("FAIL and_after got=%b want=001", {tr_we[5], tr_done[5], tr_rdy[5]}); end
    total++; if ({rf[0], rf[15]} !== 16'h3077) begin bad++; $display("FAIL and_final got=%h want=3077", {rf[0], rf[15]}); end
  endtask

  task automatic test_illegal();
    logic [15:0] ops [2];
    ops[0] = 16'h8128; ops[1] = 16'h9120;
    for (int i = 0; i < 2; i++) begin
      issue(ops[i]);
      total++; if ({tr_ill[1], tr_ill[2], tr_rdy[1], tr_rdy[2]} !== 4'b1001) begin bad++;
        $display("FAIL illegal_%h got=%b want=1001", ops[i], {tr_ill[1], tr_ill[2], tr_rdy[1], tr_rdy[2]}); end
      for (int k = 1; k <= 7; k++) begin
        total++; if ({tr_we[k], tr_done[k]} !== 2'b00) begin bad++;
          $display("FAIL illegal_%h_we k=%0d got=%b want=00", ops[i], k, {tr_we[k], tr_done[k]}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    preload(4'h1, 8'hF0); preload(4'h2, 8'h20); preload(4'hF, 8'h55);
    @(negedge clk);
    op_valid = 1'b1; opcode = 16'h8124;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      op_valid = 1'b0; opcode = 16'h0000;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({rf_we, done} !== 2'b00) begin bad++; $display("FAIL rstmid_exec got=%b want=00", {rf_we, done}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if ({op_ready, rf_we} !== 2'b10) begin bad++; $display("FAIL rstmid_after got=%b want=10", {op_ready, rf_we}); end
    repeat (3) @(negedge clk);
    total++; if ({rf[1], rf[15]} !== 16'hF055) begin bad++; $display("FAIL rstmid_regs got=%h want=f055", {rf[1], rf[15]}); end
    issue(16'h8123);
    total++; if ({tr_we[4], tr_wa[4], tr_wd[4], tr_done[4]} !== {1'b1, 4'h1, 8'hD0, 1'b1}) begin bad++;
      $display("FAIL rstmid_xor got=%b/%h/%h/%b want=1/1/d0/1", tr_we[4], tr_wa[4], tr_wd[4], tr_done[4]); end
    total++; if ({rf[1], rf[15]} !== 16'hD055) begin bad++; $display("FAIL rstmid_final got=%h want=d055", {rf[1], rf[15]}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; op_valid = 1'b0; opcode = 16'h0000;
    pl_we = 1'b0; pl_a = 4'h0; pl_d = 8'h00;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    test_reset();
    test_add();
    test_sub_rsb();
    test_vf_dest();
    test_shift();
    test_no_vf();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
